// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, host command and device response codes,
// and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for a raw PS/2 pad plus a registered falling-edge detector.
// Flops reset to 1 so the idle-high line never produces a spurious edge out of reset.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // synchronizer chain and previous-value register for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign line_sync = sync;
  assign fall      = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, device-clocked 11-bit frame, ACK check.
// Optional macro PS2_TX_ACK_CHECK_EN: when defined a high ACK sample aborts the frame with tx_err.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
  parameter int unsigned INHIBIT_CYCLES = 12_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  if (CLK_FREQ_HZ == 0 || INHIBIT_CYCLES == 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ps2_host_tx: CLK_FREQ_HZ, INHIBIT_CYCLES and TIMEOUT_CYCLES must be non-trivial");
  end

  logic clk_sync;
  logic clk_fall;
  logic data_meta;
  logic data_sync;

  ps2_line_sync u_clk_sync (
    .clk       (clk),
    .rst       (rst),
    .line_in   (ps2_clk_i),
    .line_sync (clk_sync),
    .fall      (clk_fall)
  );

  // data line only needs synchronizing; its edges carry no timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= ps2_data_i;
      data_sync <= data_meta;
    end
  end

  ps2_tx_state_e    state, state_nxt;
  logic [INH_W-1:0] inh_cnt, inh_nxt;
  logic [TO_W-1:0]  to_cnt, to_nxt;
  logic [3:0]       edge_cnt, edge_nxt;
  logic [8:0]       shreg, shreg_nxt;
  logic             ack_ok, ack_nxt;
  logic             ready_nxt, done_nxt, err_nxt, clk_oe_nxt, data_oe_nxt;
  logic             timed;
  logic             to_hit;

  // the timeout watches the device-clocked phases only; any device edge restarts it
  assign timed  = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
  assign to_hit = timed && !clk_fall && (to_cnt == TO_LAST);

  // next-state, datapath and next-output logic
  always_comb begin
    state_nxt   = state;
    inh_nxt     = inh_cnt;
    edge_nxt    = edge_cnt;
    shreg_nxt   = shreg;
    ack_nxt     = ack_ok;
    ready_nxt   = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    clk_oe_nxt  = 1'b0;
    data_oe_nxt = ps2_data_oe;

    if (!timed || clk_fall) begin
      to_nxt = '0;
    end else begin
      to_nxt = to_cnt + TO_W'(1);
    end

    case (state)
      IDLE: begin
        data_oe_nxt = 1'b0;
        if (tx_valid && tx_ready) begin
          state_nxt  = INHIBIT;
          inh_nxt    = '0;
          shreg_nxt  = {odd_parity(tx_data), tx_data};
          clk_oe_nxt = 1'b1;
        end else begin
          ready_nxt = 1'b1;
        end
      end

      INHIBIT: begin
        clk_oe_nxt = 1'b1;
        if (inh_cnt == INH_LAST) begin
          state_nxt   = REQ;
          data_oe_nxt = 1'b1;
        end else begin
          inh_nxt = inh_cnt + INH_W'(1);
        end
      end

      REQ: begin
        // start bit stays driven while the clock line is handed to the device
        state_nxt = SHIFT;
        edge_nxt  = 4'd0;
        ack_nxt   = 1'b0;
      end

      SHIFT: begin
        if (to_hit) begin
          state_nxt   = IDLE;
          err_nxt     = 1'b1;
          data_oe_nxt = 1'b0;
        end else if (clk_fall) begin
          edge_nxt = edge_cnt + 4'd1;
          if (edge_cnt == 4'd9) begin
            data_oe_nxt = 1'b0;
            state_nxt   = ACK;
          end else begin
            data_oe_nxt = ~shreg[0];
            shreg_nxt   = {1'b0, shreg[8:1]};
          end
        end else begin
          state_nxt = SHIFT;
        end
      end

      ACK: begin
        if (to_hit) begin
          state_nxt   = IDLE;
          err_nxt     = 1'b1;
          data_oe_nxt = 1'b0;
        end else if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
          ack_nxt = ~data_sync;
`else
          ack_nxt = 1'b1;
`endif
          state_nxt = WAIT_IDLE;
        end else begin
          state_nxt = ACK;
        end
      end

      WAIT_IDLE: begin
        if (to_hit) begin
          state_nxt   = IDLE;
          err_nxt     = 1'b1;
          data_oe_nxt = 1'b0;
        end else if (clk_sync && data_sync) begin
          done_nxt  = ack_ok;
          err_nxt   = ~ack_ok;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_IDLE;
        end
      end

      default: begin
        state_nxt   = IDLE;
        data_oe_nxt = 1'b0;
      end
    endcase
  end

  // state, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      edge_cnt    <= 4'd0;
      shreg       <= 9'd0;
      ack_ok      <= 1'b0;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_nxt;
      inh_cnt     <= inh_nxt;
      to_cnt      <= to_nxt;
      edge_cnt    <= edge_nxt;
      shreg       <= shreg_nxt;
      ack_ok      <= ack_nxt;
      tx_ready    <= ready_nxt;
      tx_done     <= done_nxt;
      tx_err      <= err_nxt;
      ps2_clk_oe  <= clk_oe_nxt;
      ps2_data_oe <= data_oe_nxt;
    end
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter: the sending end of the PS/2 link whose receive side is handled by the keyboard decoder. It takes one command byte per handshake (e.g. 0xED set-LEDs, 0xFF reset), runs the host request-to-send sequence, and shifts out start, 8 data bits LSB first, odd parity and stop, clocked by the device. It then checks the device ACK. It sits beside the keyboard decoder at the FPGA top level and shares the PS2_CLK/PS2_DATA open-drain pads with it.

## Interface
Parameters:
- CLK_FREQ_HZ, 100_000_000: system clock frequency.
- INHIBIT_CYCLES, 12_000: cycles PS2_CLK is held low before the request (120 us at 100 MHz).
- TIMEOUT_CYCLES, 2_000_000: maximum clk cycles between consecutive device falling edges, and the limit for the WAIT_IDLE state (20 ms).

Ports:
- clk  in  1  system clock. One clock domain; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- tx_valid  in  1  command request.
- tx_data  in  8  command byte.
- tx_ready  out  1  idle and able to accept a byte.
- tx_done  out  1  one-cycle pulse: frame sent and closed.
- tx_err  out  1  one-cycle pulse: frame aborted.
- ps2_clk_i  in  1  raw PS2_CLK pad input.
- ps2_data_i  in  1  raw PS2_DATA pad input.
- ps2_clk_oe  out  1  1 = drive PS2_CLK low; 0 = release. The top level ties the pad as oe ? 0 : z.
- ps2_data_oe  out  1  1 = drive PS2_DATA low; 0 = release.

## Operation
- ps2_clk_i and ps2_data_i each pass through a 2-FF synchronizer. A device falling edge (fe) is detected on the synchronized clock line.
- Handshake: a byte is accepted when tx_valid && tx_ready. tx_data is latched at acceptance. tx_valid is ignored while tx_ready = 0.
- Parity bit = ~^tx_data (odd parity).
- States:
  - IDLE: both oe = 0, tx_ready = 1. On accept, go to INHIBIT.
  - INHIBIT: clk_oe = 1 for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: clk_oe = 1 and data_oe = 1 (start bit 0) for exactly 1 cycle, then go to SHIFT.
  - SHIFT: clk_oe = 0. The edge counter n runs 1..11 on each fe.
    - At fe n = 1..8, data_oe = ~data[n-1].
    - At n = 9, data_oe = ~parity.
    - At n = 10, data_oe = 0 (stop bit, line released); go to ACK.
  - ACK: at fe 11, sample synchronized ps2_data. ACK is valid when the sample is 0. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until both synchronized lines read 1. Then pulse tx_done (ACK valid) or tx_err (ACK bad), and return to IDLE.
- Timeout: the timeout counter clears on entry to SHIFT and on every fe, and runs in SHIFT, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES, both oe go to 0, tx_err pulses, and the FSM returns to IDLE.
- tx_done and tx_err are mutually exclusive. Each pulses at most once per accepted byte.
- Reset mid-frame releases both lines immediately and returns to IDLE. No done or err pulse is generated.

## Timing
- Reset values: tx_ready = 1, tx_done = 0, tx_err = 0, ps2_clk_oe = 0, ps2_data_oe = 0. All outputs are registered.
- Accept at edge k: tx_ready = 0 and clk_oe = 1 from edge k+1.
- data_oe asserts at edge k+1+INHIBIT_CYCLES. clk_oe deasserts one cycle later.
- Bit update latency: data_oe changes 3 clk cycles after the raw ps2_clk_i falling edge (2 synchronizer stages plus edge register). This is well inside the 5 us minimum low time of the device clock.
- tx_ready returns to 1 one cycle after the tx_done/tx_err pulse. With tx_valid held high, the next frame starts on that cycle.

## Configuration
- PS2_TX_ACK_CHECK_EN:
  - Defined: the ACK sample is evaluated; ACK = 1 gives tx_err.
  - Undefined: fe 11 is still awaited, but the sample is ignored; the frame always ends with tx_done unless a timeout occurs.

## Structure
- Shared package ps2_pkg holds:
  - the FSM state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE);
  - command constants PS2_CMD_SET_LED = 8'hED, PS2_CMD_RESET = 8'hFF, PS2_CMD_ECHO = 8'hEE;
  - the response constant PS2_RSP_ACK = 8'hFA.
- One sub-module, ps2_line_sync: 2-FF synchronizer plus falling-edge detector, instantiated for the clock line. The data line uses the synchronizer only.

## Test plan
- Send 0xED; the device BFM clocks at 12.5 kHz and ACKs. Frame on the wire is 0,1,0,1,1,0,1,1,1, parity 1, stop 1. Expect one tx_done pulse, tx_err = 0, and tx_ready back to 1.
- Send 0x01. Expect parity bit 0. Send 0x00. Expect parity bit 1.
- Device leaves DATA high at clock 11. With PS2_TX_ACK_CHECK_EN: expect a tx_err pulse. Without it: expect a tx_done pulse.
- Device never clocks after REQ. Expect a tx_err pulse exactly TIMEOUT_CYCLES cycles after SHIFT entry, with both oe = 0.
- Assert rst after fe 5. Expect both oe = 0 and tx_ready = 1 immediately, with no done or err pulse.
- Hold tx_valid high with 0xFF then 0xEE. Expect two complete frames, tx_ready = 0 throughout each, and tx_data changes during a frame ignored.
